// File: rtl/freq_meas_sequencer.sv
// Gated frequency-measurement sequencer: counts synchronized rising edges of in_sig
// over a ranged gate, scales the count to Hz and optionally auto-ranges the gate.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] freq;
    logic        ovf;
  } scaled_t;

  function automatic logic [1:0] clamp_range(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd2 : sel;
  endfunction

  // Range 1 and 2 gates are 10x and 100x shorter, so the count is scaled back up
  // with shift-add multiplies in 40 bits and saturated to 32 bits.
  function automatic scaled_t scale_sat(input logic [31:0] count, input logic [1:0] rng);
    logic [39:0] x;
    logic [39:0] x10;
    logic [39:0] x100;
    logic [39:0] prod;
    scaled_t     res;
    x    = {8'd0, count};
    x10  = (x << 3) + (x << 1);
    x100 = (x10 << 3) + (x10 << 1);
    case (rng)
      2'd0:    prod = x;
      2'd1:    prod = x10;
      default: prod = x100;
    endcase
    if (|prod[39:32]) begin
      res.freq = 32'hFFFF_FFFF;
      res.ovf  = 1'b1;
    end else begin
      res.freq = prod[31:0];
      res.ovf  = 1'b0;
    end
    return res;
  endfunction

endpackage

module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned HI_COUNT    = 100000,
  parameter int unsigned LO_COUNT    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_sig,
  input  logic        run,
  input  logic        start,
  input  logic        auto_range,
  input  logic [1:0]  range_sel,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic [1:0]  range,
  output logic        busy,
  output logic        overflow
);

  localparam logic [31:0] GATE_LAST0 = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] GATE_LAST1 = 32'(GATE_CYCLES / 10 - 1);
  localparam logic [31:0] GATE_LAST2 = 32'(GATE_CYCLES / 100 - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] HI_THRESH  = 32'(HI_COUNT);
  localparam logic [31:0] LO_THRESH  = 32'(LO_COUNT);

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] gate_last_q, gate_last_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  range_q, range_d;
  logic [1:0]  auto_rng_q, auto_rng_d;
  logic        auto_gate_q, auto_gate_d;
  logic [31:0] freq_q, freq_d;
  logic        ovf_q, ovf_d;

  logic        rise;
  logic        gate_done;
  logic        hold_done;
  logic        enter_gate;
  logic [1:0]  gate_rng;
  scaled_t     scaled;

  // sync_q[0] may go metastable, sync_q[1] is the clean sample, sync_q[2] its delay.
  assign rise      = sync_q[1] & ~sync_q[2];
  assign gate_done = (state_q == S_GATE) && (timer_q == gate_last_q);
  assign hold_done = (timer_q == HOLD_LAST);

  // NOTE: async reset in the sensitivity list and non-blocking (<=) assignments keep
  // every flop updating from the same pre-edge values, with no simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run || start) state_d = S_GATE;
      S_GATE:  if (gate_done) state_d = S_LATCH;
      S_LATCH: state_d = S_HOLD;
      S_HOLD:  if (hold_done) state_d = run ? S_GATE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    freq_valid = (state_q == S_LATCH);
  end

  always_comb begin
    sync_d      = {sync_q[1:0], in_sig};
    timer_d     = timer_q;
    gate_last_d = gate_last_q;
    count_d     = count_q;
    range_d     = range_q;
    auto_rng_d  = auto_rng_q;
    auto_gate_d = auto_gate_q;
    freq_d      = freq_q;
    ovf_d       = ovf_q;
    scaled      = '0;
    gate_rng    = auto_range ? auto_rng_q : clamp_range(range_sel);
    enter_gate  = (state_q != S_GATE) && (state_d == S_GATE);

    if (enter_gate) begin
      // Gate length and mode are frozen here for the whole measurement.
      timer_d     = '0;
      count_d     = '0;
      range_d     = gate_rng;
      auto_rng_d  = gate_rng;
      auto_gate_d = auto_range;
      case (gate_rng)
        2'd0:    gate_last_d = GATE_LAST0;
        2'd1:    gate_last_d = GATE_LAST1;
        default: gate_last_d = GATE_LAST2;
      endcase
    end else begin
      case (state_q)
        S_GATE: begin
          timer_d = timer_q + 32'd1;
          if (rise && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
          // Scale the final count (including an edge on the last gate cycle) so the
          // new freq is on the output during the LATCH cycle alongside freq_valid.
          if (gate_done) begin
            scaled = scale_sat(count_d, range_q);
            freq_d = scaled.freq;
            ovf_d  = scaled.ovf;
          end
        end
        S_LATCH: begin
          timer_d = '0;
          if (auto_gate_q) begin
            if ((count_q >= HI_THRESH) && (range_q < 2'd2))     auto_rng_d = range_q + 2'd1;
            else if ((count_q < LO_THRESH) && (range_q > 2'd0)) auto_rng_d = range_q - 2'd1;
            else                                                auto_rng_d = range_q;
          end
        end
        S_HOLD:  timer_d = timer_q + 32'd1;
        default: timer_d = timer_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      timer_q     <= '0;
      gate_last_q <= '0;
      count_q     <= '0;
      range_q     <= '0;
      auto_rng_q  <= '0;
      auto_gate_q <= 1'b0;
      freq_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      timer_q     <= timer_d;
      gate_last_q <= gate_last_d;
      count_q     <= count_d;
      range_q     <= range_d;
      auto_rng_q  <= auto_rng_d;
      auto_gate_q <= auto_gate_d;
      freq_q      <= freq_d;
      ovf_q       <= ovf_d;
    end
  end

  assign freq     = freq_q;
  assign overflow = ovf_q;
  assign range    = range_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Bench for freq_meas_sequencer: a table of single-shot measurements, continuous-mode
// sequences and a reset abort, with results checked from a scoreboard queue.
module tb_freq_meas_sequencer;
  import freq_meas_pkg::*;

  localparam int unsigned GC = 1000;
  localparam int unsigned HC = 10;
  localparam int unsigned HI = 50;
  localparam int unsigned LO = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_sig = 1'b0;
  logic        run = 1'b0;
  logic        start = 1'b0;
  logic        auto_range = 1'b0;
  logic [1:0]  range_sel = 2'd0;
  logic [31:0] freq;
  logic        freq_valid;
  logic [1:0]  range;
  logic        busy;
  logic        overflow;

  freq_meas_sequencer #(
    .GATE_CYCLES(GC), .HOLD_CYCLES(HC), .HI_COUNT(HI), .LO_COUNT(LO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_sig(in_sig), .run(run), .start(start),
    .auto_range(auto_range), .range_sel(range_sel), .freq(freq),
    .freq_valid(freq_valid), .range(range), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        auto_m;
    logic [1:0]  sel;
    int          period;   // 0 = input idle (or single probe edge)
    int          probe;    // cycles after start for a single edge, -1 = none
    logic [31:0] freq_a;   // a phase-dependent count allows either of two results
    logic [31:0] freq_b;
    logic [1:0]  rng;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] freq_a;
    logic [31:0] freq_b;
    logic [1:0]  rng;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] cnt;
    logic [1:0]  rng;
    logic [31:0] f;
    logic        o;
  } ucase_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   period = 0;
  bit   probe_on = 1'b0;
  int   probe_at = 0;
  int   cyc = 0;
  int   ph = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Input generator: runs just after each falling edge, after the main sequence.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (period != 0) begin
        ph     = (ph + 1) % period;
        in_sig = (ph < period / 2);
      end else begin
        in_sig = probe_on && (cyc >= probe_at);
      end
    end
  end

  // Result monitor: every freq_valid pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (freq_valid === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: got freq_valid=1 freq=%0d, want no result", freq);
        end else begin
          e = sb_q.pop_front();
          if (freq !== e.freq_a && freq !== e.freq_b) begin
            n_err++;
            $display("FAIL result_freq: got %0d, want %0d or %0d", freq, e.freq_a, e.freq_b);
          end
          check("result_range", {30'd0, range}, {30'd0, e.rng});
          check("result_overflow", {31'd0, overflow}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no summary by %0t, want completion", $time);
    $fatal(1, "time limit reached");
  end

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    if (i == budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d after %0d cycles, want idle",
               name, busy, sb_q.size(), budget);
    end
  endtask

  task automatic shot(input vec_t v);
    auto_range = v.auto_m;
    range_sel  = v.sel;
    period     = v.period;
    probe_on   = 1'b0;
    repeat (2 * v.period + 20) @(negedge clk);
    sb_q.push_back('{v.freq_a, v.freq_b, v.rng, v.ovf});
    start = 1'b1;
    if (v.probe >= 0) begin
      probe_at = cyc + 1 + v.probe;
      probe_on = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_done("shot", 3000);
    probe_on = 1'b0;
  endtask

  // Three continuous results, with run dropped partway into the third gate.
  task automatic run_cont(input string name, input logic auto_m, input logic [1:0] sel,
                          input int per, input exp_t e0, input exp_t e1, input exp_t e2);
    int i;
    auto_range = auto_m;
    range_sel  = sel;
    period     = per;
    repeat (2 * per + 20) @(negedge clk);
    sb_q.push_back(e0);
    sb_q.push_back(e1);
    sb_q.push_back(e2);
    run = 1'b1;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb_q.size() <= 1) break;
    end
    if (i == 4000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_cont_timeout: got pending=%0d, want 1", name, sb_q.size());
    end
    repeat (HC + 20) @(negedge clk);
    check({name, "_busy_at_drop"}, {31'd0, busy}, 32'd1);
    run = 1'b0;
    wait_done(name, 3000);
    repeat (300) @(negedge clk);
    check({name, "_idle_after_drop"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t   tbl[15];
  ucase_t uc[6];
  scaled_t s;

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 100, -1, 32'd10,  32'd10,  2'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 100, -1, 32'd10,  32'd10,  2'd1, 1'b0};
    tbl[2]  = '{1'b0, 2'd3, 100, -1, 32'd0,   32'd100, 2'd2, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 0,    0, 32'd100, 32'd100, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 0,    8, 32'd100, 32'd100, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 0,    9, 32'd0,   32'd0,   2'd2, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 0,   -1, 32'd0,   32'd0,   2'd0, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 10,  -1, 32'd100, 32'd100, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 10,  -1, 32'd100, 32'd100, 2'd1, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 10,  -1, 32'd100, 32'd100, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 2'd2, 400, -1, 32'd0,   32'd100, 2'd2, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 400, -1, 32'd0,   32'd100, 2'd2, 1'b0};
    tbl[12] = '{1'b1, 2'd0, 400, -1, 32'd0,   32'd10,  2'd1, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 400, -1, 32'd2,   32'd3,   2'd0, 1'b0};
    tbl[14] = '{1'b1, 2'd2, 400, -1, 32'd2,   32'd3,   2'd0, 1'b0};

    uc[0] = '{32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 1'b0};
    uc[1] = '{32'd429496729, 2'd1, 32'd4294967290, 1'b0};
    uc[2] = '{32'd429496730, 2'd1, 32'hFFFF_FFFF, 1'b1};
    uc[3] = '{32'd42949672,  2'd2, 32'd4294967200, 1'b0};
    uc[4] = '{32'd42949673,  2'd2, 32'hFFFF_FFFF, 1'b1};
    uc[5] = '{32'd7,         2'd3, 32'd700, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_freq", freq, 32'd0);
    check("reset_valid", {31'd0, freq_valid}, 32'd0);
    check("reset_range", {30'd0, range}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 15; i++) shot(tbl[i]);

    // Reset in the middle of a gate aborts without a result.
    auto_range = 1'b0;
    range_sel  = 2'd2;
    period     = 100;
    repeat (220) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_mid_gate", {31'd0, busy}, 32'd1);
    check("range_mid_gate", {30'd0, range}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_freq", freq, 32'd0);
    check("abort_valid", {31'd0, freq_valid}, 32'd0);
    check("abort_range", {30'd0, range}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    check("busy_after_abort", {31'd0, busy}, 32'd0);

    run_cont("auto_run", 1'b1, 2'd0, 10,
             '{32'd100, 32'd100, 2'd0, 1'b0},
             '{32'd100, 32'd100, 2'd1, 1'b0},
             '{32'd100, 32'd100, 2'd1, 1'b0});
    run_cont("manual_run", 1'b0, 2'd1, 100,
             '{32'd10, 32'd10, 2'd1, 1'b0},
             '{32'd10, 32'd10, 2'd1, 1'b0},
             '{32'd10, 32'd10, 2'd1, 1'b0});

    for (int i = 0; i < 6; i++) begin
      s = scale_sat(uc[i].cnt, uc[i].rng);
      check($sformatf("scale_freq_%0d", i), s.freq, uc[i].f);
      check($sformatf("scale_ovf_%0d", i), {31'd0, s.ovf}, {31'd0, uc[i].o});
    end

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meas_sequencer.md
Name: freq_meas_sequencer

Overview:
- Measurement controller that sequences gated frequency counting of an external input on the 100 MHz system clock.
- Opens a timed gate and counts input rising edges during it, then scales and latches the result as a 32-bit Hz value.
- Optionally auto-ranges the gate length between measurements.
- Output feeds disp_controller's displayed_number directly.

Parameters:
- GATE_CYCLES, 100000000, clk cycles in range-0 gate (1 s at 100 MHz); range 1 = GATE_CYCLES/10, range 2 = GATE_CYCLES/100 (integer division).
- HOLD_CYCLES, 1000, idle clk cycles between measurements in continuous mode (minimum 1).
- HI_COUNT, 100000, raw edge count at or above which auto-range moves to the next shorter gate.
- LO_COUNT, 1000, raw edge count below which auto-range moves to the next longer gate.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- in_sig  input  1  asynchronous signal under measurement.
- run  input  1  level; 1 = continuous measurements.
- start  input  1  one-cycle pulse; starts a single measurement when IDLE and run=0.
- auto_range  input  1  1 = automatic range selection; 0 = use range_sel.
- range_sel  input  2  manual range; 0..2 valid, 3 treated as 2.
- freq  output  32  latched scaled result in Hz.
- freq_valid  output  1  one-cycle pulse when freq updates.
- range  output  2  range used by the current or last gate.
- busy  output  1  high in GATE, LATCH and HOLD.
- overflow  output  1  set with freq_valid when the scaled result saturated.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - freq=0, freq_valid=0, range=0, busy=0, overflow=0.
  - Edge counter and synchronizer cleared.
- Input path:
  - 2-flop synchronizer on in_sig, plus a delay flop for edge detection.
  - rise = sync & ~prev.
  - Latency: 3 clk cycles from an in_sig transition to the rise pulse.
- IDLE:
  - busy=0.
  - Moves to GATE when run=1, or when start=1.
  - On entry to GATE: gate timer=0, edge count=0, and the gate length is fixed for the whole gate.
  - Gate length comes from range_sel (if auto_range=0) or the internal range register (if auto_range=1).
- GATE:
  - Active for exactly Gn cycles (Gn = gate length for the range).
  - Each cycle with rise=1 increments the 32-bit count; the count saturates at 32'hFFFFFFFF.
  - After cycle Gn, moves to LATCH.
- LATCH (1 cycle):
  - Scaled value = count × 1, 10 or 100 for range 0, 1 or 2.
  - Computed in 40 bits using shift-add (x<<3 + x<<1).
  - If the result exceeds 32 bits, freq=32'hFFFFFFFF and overflow=1; otherwise freq=result and overflow=0.
  - freq_valid=1 for this cycle only.
  - Auto-range update (only if auto_range=1) applies to the next gate:
    - count ≥ HI_COUNT and range<2 → range+1.
    - count < LO_COUNT and range>0 → range−1.
    - Otherwise range is unchanged.
  - Moves to HOLD.
- HOLD:
  - Waits HOLD_CYCLES cycles.
  - Then goes to GATE if run=1, else IDLE.
- Output holding: freq, overflow and range hold their values between LATCH events.
- Mid-operation events:
  - Deasserting run mid-measurement does not abort; the current measurement completes, then the block goes to IDLE.
  - start is ignored while busy=1 or run=1.
  - Changes to range_sel or auto_range mid-gate have no effect until the next GATE entry.
- Manual mode: when auto_range=0 the range output follows the gate actually used, i.e. range_sel sampled at GATE entry with 3 mapped to 2.
- Reset mid-gate: all state is cleared immediately; no freq_valid is produced.
- Boundary conditions:
  - No edges during the gate → freq=0, freq_valid still pulses.
  - Edge on the final gate cycle is counted; an edge on the LATCH cycle is not.

Test Plan:
Bench parameters: GATE_CYCLES=1000, HOLD_CYCLES=10, HI_COUNT=50, LO_COUNT=5; gates are 1000/100/10 cycles.
- Single shot, manual range 0: in_sig period 100 clk, run=0, one start pulse → after 1000 gate cycles, one freq_valid with freq=10, overflow=0, range=0, then busy=0 and no further valid.
- Manual range 1: same input, range_sel=1 → freq=10 (count 1 ×10); range_sel=3 → gate 10 cycles, range=2, freq=0 or 100 depending on phase (check against the bench's edge count model).
- Auto up-range: in_sig period 10 clk, run=1, auto_range=1, start at range 0 → 1st result count 100, freq=100, range→1; 2nd result count 10, freq=100, range stays 1.
- Auto down-range: in_sig period 400 clk at range 2 → count 0, range→1; next count 0, range→0; at range 0, freq=2 or 3 and range stays 0.
- Saturation: force the count path with a stimulus giving count ≥ 42949673 at range 2 (large-GATE bench variant), or unit-check LATCH → freq=32'hFFFFFFFF, overflow=1.
- Reset and run mid-op: assert rst_n=0 mid-GATE → all outputs 0 within the same cycle and no freq_valid; separately, drop run mid-GATE → exactly one more freq_valid, then IDLE.
